// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned SW_DEF = 4;

  localparam logic [DW_DEF-1:0] DIV0_QUOT = {DW_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned SW = 4
) (
  input  logic [SW-1:0] rem,
  input  logic          din,
  input  logic [SW-1:0] divisor,
  output logic [SW-1:0] rem_nxt,
  output logic          q
);

  logic [SW:0] pr;
  logic [SW:0] diff;

  always_comb begin
    pr   = {rem, din};
    diff = pr - {1'b0, divisor};
    q    = (pr >= {1'b0, divisor});
    // rem < divisor on entry, so the difference always fits in SW bits
    rem_nxt = q ? diff[SW-1:0] : pr[SW-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, operands captured on start's falling edge.
// Optional: SEQ_DIV_EARLY_EXIT_EN skips iteration when dividend < divisor.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  input  logic          start,
  output logic [DW-1:0] quotient,
  output logic [SW-1:0] remainder,
  output logic          valid,
  output logic          busy,
  output logic          div_by_zero
);

  localparam int unsigned CW = $clog2(DW + 1);
  localparam logic [DW-1:0] Q_ALL_ONES = (DW == DW_DEF) ? DW'(DIV0_QUOT) : {DW{1'b1}};

  div_state_t    state, state_nxt;
  logic [DW-1:0] dq, dq_nxt;
  logic [SW-1:0] dvs, dvs_nxt;
  logic [SW-1:0] rem, rem_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [DW-1:0] quotient_nxt;
  logic [SW-1:0] remainder_nxt;
  logic          valid_nxt, busy_nxt, dz_nxt;
  logic          start_d;
  logic          start_edge;
  logic [SW-1:0] step_rem;
  logic          step_q;

  assign start_edge = start_d & ~start;

  div_step #(.SW(SW)) u_step (
    .rem     (rem),
    .din     (dq[DW-1]),
    .divisor (dvs),
    .rem_nxt (step_rem),
    .q       (step_q)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      start_d     <= 1'b0;
      dq          <= '0;
      dvs         <= '0;
      rem         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_d     <= start;
      dq          <= dq_nxt;
      dvs         <= dvs_nxt;
      rem         <= rem_nxt;
      count       <= count_nxt;
      quotient    <= quotient_nxt;
      remainder   <= remainder_nxt;
      valid       <= valid_nxt;
      busy        <= busy_nxt;
      div_by_zero <= dz_nxt;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_nxt     = state;
    dq_nxt        = dq;
    dvs_nxt       = dvs;
    rem_nxt       = rem;
    count_nxt     = count;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    dz_nxt        = div_by_zero;
    valid_nxt     = 1'b0;
    busy_nxt      = busy;

    // busy covers the valid cycle, then drops
    if (valid) busy_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (start_edge && !busy) begin
          dq_nxt    = dividend;
          dvs_nxt   = divisor;
          rem_nxt   = '0;
          count_nxt = CW'(DW);
          busy_nxt  = 1'b1;
          if (divisor == '0) begin
            state_nxt = DONE;
          end
`ifdef SEQ_DIV_EARLY_EXIT_EN
          else if (dividend < DW'(divisor)) begin
            dq_nxt    = '0;
            rem_nxt   = dividend[SW-1:0];
            state_nxt = DONE;
          end
`endif
          else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        dq_nxt    = {dq[DW-2:0], step_q};
        rem_nxt   = step_rem;
        count_nxt = count - CW'(1);
        if (count == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        valid_nxt = 1'b1;
        state_nxt = IDLE;
        if (dvs == '0) begin
          quotient_nxt  = Q_ALL_ONES;
          remainder_nxt = '0;
          dz_nxt        = 1'b1;
        end else begin
          quotient_nxt  = dq;
          remainder_nxt = rem;
          dz_nxt        = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed operations, monitor checks every valid pulse.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       start = 1'b0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       valid, busy, div_by_zero;

  seq_restoring_divider dut (
    .clk         (clk),
    .rst         (rst),
    .dividend    (dividend),
    .divisor     (divisor),
    .start       (start),
    .quotient    (quotient),
    .remainder   (remainder),
    .valid       (valid),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         vcyc;
    int         lat;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   busy_run = 0;

`ifdef SEQ_DIV_EARLY_EXIT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 9;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per valid pulse
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_run++;
    else busy_run = 0;
    if (valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_quot"}, int'(quotient), int'(e.q));
        check({e.name, "_rem"}, int'(remainder), int'(e.r));
        check({e.name, "_dz"}, int'(div_by_zero), int'(e.dz));
        check({e.name, "_latency"}, cyc, e.vcyc);
        check({e.name, "_busy_len"}, busy_run, e.lat + 1);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [3:0] b, input logic [7:0] q,
                       input logic [3:0] r, input logic dz, input int lat,
                       input bit push, input string name);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    if (push) sb.push_back('{q, r, dz, cyc + 1 + lat, lat, name});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_in_time"}, int'(n < 200), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_quot", int'(quotient), 0);
    check("rst_rem", int'(remainder), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dz", int'(div_by_zero), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9, 1'b1, "t1_200_7");
    wait_done("t1");

    issue(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 9, 1'b1, "t2_255_15");
    wait_done("t2a");
    issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9, 1'b1, "t2_255_1");
    wait_done("t2b");

    issue(8'd100, 4'd0, 8'hFF, 4'd0, 1'b1, 1, 1'b1, "t3_100_0");
    wait_done("t3a");
    issue(8'd10, 4'd3, 8'd3, 4'd1, 1'b0, 9, 1'b1, "t3_10_3");
    wait_done("t3b");

    issue(8'd3, 4'd9, 8'd0, 4'd3, 1'b0, LAT_SMALL, 1'b1, "t4_3_9");
    wait_done("t4");

    // Restart attempt with new operands mid-operation must be ignored
    issue(8'd50, 4'd5, 8'd10, 4'd0, 1'b0, 9, 1'b1, "t5_50_5");
    repeat (4) @(negedge clk);
    dividend = 8'd99;
    divisor  = 4'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5");
    repeat (3) @(negedge clk);

    // Reset mid-operation aborts with no valid pulse
    issue(8'd77, 4'd6, 8'd12, 4'd5, 1'b0, 9, 1'b0, "t6_abort");
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rst_quot", int'(quotient), 0);
    check("t6_rst_rem", int'(remainder), 0);
    check("t6_rst_valid", int'(valid), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    issue(8'd77, 4'd6, 8'd12, 4'd5, 1'b0, 9, 1'b1, "t6_77_6");
    wait_done("t6");
    repeat (3) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
